// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front-panel logic.
//   btn_state_t : per-channel button FSM encoding (RELEASED / HELD / LONG)
//   BOARD_DIV   : filter-tick prescaler for the board clock
//   cnt_width   : width of a counter that must reach 'limit' without wrapping
package stopwatch_pkg;

    localparam int BOARD_DIV = 500_000;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HELD     = 2'd1,
        LONG     = 2'd2
    } btn_state_t;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, tick-based stability filter,
// press/release/long pulse generation and auto-repeat.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   tick       : one-cycle filter tick from the shared prescaler
//   button     : raw asynchronous button input
//   level      : debounced level, 1 = pressed
//   press      : 1-cycle pulse on accepted press and on each auto-repeat
//   released   : 1-cycle pulse on accepted release ('release' is a reserved word)
//   long       : 1-cycle pulse when held LONG_TICKS ticks
module debounce_channel
    import stopwatch_pkg::*;
#(
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 0,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic button,
    output logic level,
    output logic press,
    output logic released,
    output logic long
);

    localparam int SW = cnt_width(STABLE_TICKS);
    localparam int HW = cnt_width((LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS);
    localparam logic INVERT = (ACTIVE_LOW != 0);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

    logic             sync0_reg, sync1_reg;
    logic             level_reg, level_next;
    logic [SW-1:0]    stab_reg, stab_next;
    logic             accept;
    logic             accept_press, accept_release;
    btn_state_t       state_reg, state_next;
    logic [HW-1:0]    hold_reg, hold_next;
    logic             press_reg, press_next;
    logic             release_reg, release_next;
    logic             long_reg, long_next;

    // Synchroniser; polarity is normalised before the first flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0_reg <= 1'b0;
            sync1_reg <= 1'b0;
        end else begin
            sync0_reg <= button ^ INVERT;
            sync1_reg <= sync0_reg;
        end
    end

    // Stability filter: any cycle agreeing with the current level restarts
    // qualification, so only an uninterrupted run of STABLE_TICKS ticks flips it.
    always_comb begin
        stab_next  = stab_reg;
        level_next = level_reg;
        accept     = 1'b0;
        if (sync1_reg == level_reg) begin
            stab_next = '0;
        end else if (tick) begin
            if (stab_reg == STABLE_LAST) begin
                accept     = 1'b1;
                level_next = ~level_reg;
                stab_next  = '0;
            end else begin
                stab_next = stab_reg + SW'(1);
            end
        end
    end

    assign accept_press   = accept & ~level_reg;
    assign accept_release = accept &  level_reg;

    // Hold/long/repeat FSM. Release is checked first in every held state so
    // that it cancels a long or repeat falling on the same tick.
    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        case (state_reg)
            RELEASED: begin
                if (accept_press) begin
                    state_next = HELD;
                    hold_next  = '0;
                    press_next = 1'b1;
                end
            end
            HELD: begin
                if (accept_release) begin
                    state_next   = RELEASED;
                    hold_next    = '0;
                    release_next = 1'b1;
                end else if (tick) begin
                    if (hold_reg == LONG_LAST) begin
                        state_next = LONG;
                        hold_next  = '0;
                        long_next  = 1'b1;
                    end else begin
                        hold_next = hold_reg + HW'(1);
                    end
                end
            end
            LONG: begin
                if (accept_release) begin
                    state_next   = RELEASED;
                    hold_next    = '0;
                    release_next = 1'b1;
                end else if (REPEAT_TICKS > 0 && tick) begin
                    if (hold_reg == REPEAT_LAST) begin
                        hold_next  = '0;
                        press_next = 1'b1;
                    end else begin
                        hold_next = hold_reg + HW'(1);
                    end
                end
            end
            default: begin
                state_next = RELEASED;
                hold_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_reg   <= 1'b0;
            stab_reg    <= '0;
            state_reg   <= RELEASED;
            hold_reg    <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            long_reg    <= 1'b0;
        end else begin
            level_reg   <= level_next;
            stab_reg    <= stab_next;
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            long_reg    <= long_next;
        end
    end

    assign level    = level_reg;
    assign press    = press_reg;
    assign released = release_reg;
    assign long     = long_reg;

endmodule

// File: rtl/debounce_bank.sv
// N-channel button conditioner for the stopwatch front panel.
// A single prescaler produces the filter tick shared by all channels.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   button[N]  : raw asynchronous button inputs
//   level[N]   : debounced levels, 1 = pressed
//   press[N]   : press / auto-repeat pulses
//   released[N]: release pulses ('release' is a reserved word)
//   long[N]    : long-press pulses
module debounce_bank
    import stopwatch_pkg::*;
#(
    parameter int N            = 4,
    parameter int DIV          = BOARD_DIV,
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 0,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] button,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] released,
    output logic [N-1:0] long
);

    // DIV=1 keeps a 1-bit counter pinned at 0, which makes tick constant 1.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_reg;
    logic          tick;

    assign tick = (pre_reg == PRE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_reg <= '0;
        end else if (tick) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + PW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            debounce_channel #(
                .STABLE_TICKS(STABLE_TICKS),
                .LONG_TICKS  (LONG_TICKS),
                .REPEAT_TICKS(REPEAT_TICKS),
                .ACTIVE_LOW  (ACTIVE_LOW)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .tick    (tick),
                .button  (button[gi]),
                .level   (level[gi]),
                .press   (press[gi]),
                .released(released[gi]),
                .long    (long[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank (N=2, DIV=4, STABLE=3, LONG=8, REPEAT=4).
// Two instances run side by side: active-high, and active-low with inverted
// stimulus; both are held to the same expectations.
// Time base: after reset release, edge k is the k-th rising edge; ticks fall on
// edges 4*t. Stimulus rows are driven just after tick edge 4*t.
module tb_debounce_bank;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   btn_tbl = 2'b00;
    logic         bnc = 1'b0;
    bit           bounce_en = 1'b0;
    logic [1:0]   btn_a, btn_n;
    logic [1:0]   lvl_a, prs_a, rel_a, lng_a;
    logic [1:0]   lvl_n, prs_n, rel_n, lng_n;

    assign btn_a = btn_tbl ^ {bnc, 1'b0};
    assign btn_n = ~btn_a;

    always #5 clk = ~clk;

    debounce_bank #(.N(N), .DIV(4), .STABLE_TICKS(3), .LONG_TICKS(8),
                    .REPEAT_TICKS(4), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .reset(reset), .button(btn_a),
        .level(lvl_a), .press(prs_a), .released(rel_a), .long(lng_a));

    debounce_bank #(.N(N), .DIV(4), .STABLE_TICKS(3), .LONG_TICKS(8),
                    .REPEAT_TICKS(4), .ACTIVE_LOW(1)) dut_n (
        .clk(clk), .reset(reset), .button(btn_n),
        .level(lvl_n), .press(prs_n), .released(rel_n), .long(lng_n));

    typedef struct {
        int         scen;
        int         tick;
        logic [1:0] btn;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rls;
        logic [1:0] lng;
    } row_t;

    typedef struct {
        int         edge_no;
        logic [1:0] prs;
        logic [1:0] rls;
        logic [1:0] lng;
    } exp_t;

    row_t rows[$];
    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Monitor: every pulse seen is matched against the next expected event.
    initial forever begin
        exp_t e;
        @(posedge clk);
        cyc = reset ? 0 : cyc + 1;
        #1;
        if (!reset && ((prs_a | rel_a | lng_a | prs_n | rel_n | lng_n) != 2'b00)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL stray_pulse edge=%0d got a:p=%b r=%b l=%b n:p=%b r=%b l=%b required none",
                         cyc, prs_a, rel_a, lng_a, prs_n, rel_n, lng_n);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.edge_no || prs_a !== e.prs || rel_a !== e.rls || lng_a !== e.lng ||
                    prs_n !== e.prs || rel_n !== e.rls || lng_n !== e.lng) begin
                    miscompares++;
                    $display("FAIL pulse edge=%0d got a:p=%b r=%b l=%b n:p=%b r=%b l=%b required edge=%0d p=%b r=%b l=%b",
                             cyc, prs_a, rel_a, lng_a, prs_n, rel_n, lng_n,
                             e.edge_no, e.prs, e.rls, e.lng);
                end
            end
        end
    end

    // Contact bounce on channel 1: toggles every 5 cycles while enabled.
    initial forever begin
        repeat (5) @(posedge clk);
        #1;
        bnc = bounce_en ? ~bnc : 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL timeout bench did not complete, required completion before 100000");
        $fatal(1, "timeout");
    end

    task automatic add(input int s, input int t, input logic [1:0] b, input logic [1:0] l,
                       input logic [1:0] p, input logic [1:0] r, input logic [1:0] g);
        row_t x;
        x.scen = s; x.tick = t; x.btn = b; x.lvl = l; x.prs = p; x.rls = r; x.lng = g;
        rows.push_back(x);
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({lvl_a, prs_a, rel_a, lng_a, lvl_n, prs_n, rel_n, lng_n} !== 16'h0) begin
            miscompares++;
            $display("FAIL %s got a:lvl=%b p=%b r=%b l=%b n:lvl=%b p=%b r=%b l=%b required all 0",
                     name, lvl_a, prs_a, rel_a, lng_a, lvl_n, prs_n, rel_n, lng_n);
        end
    endtask

    task automatic wait_tick(input int k);
        int guard = 0;
        while (cyc < 4 * k && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != 4 * k) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_sync got edge=%0d required edge=%0d", cyc, 4 * k);
        end
    endtask

    task automatic run_scen(input int s);
        row_t sel[$];
        exp_t e;
        foreach (rows[i]) if (rows[i].scen == s) sel.push_back(rows[i]);
        // Reset is asserted mid-cycle; outputs must clear before the next edge.
        btn_tbl = sel[0].btn;
        reset = 1'b1;
        #1;
        check_zero($sformatf("reset_async scen%0d", s));
        foreach (sel[i]) begin
            if ((sel[i].prs | sel[i].rls | sel[i].lng) != 2'b00) begin
                e.edge_no = 4 * sel[i].tick;
                e.prs = sel[i].prs; e.rls = sel[i].rls; e.lng = sel[i].lng;
                exp_q.push_back(e);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check_zero($sformatf("reset_hold scen%0d", s));
        reset = 1'b0;
        foreach (sel[i]) begin
            wait_tick(sel[i].tick);
            vectors++;
            if (lvl_a !== sel[i].lvl || lvl_n !== sel[i].lvl) begin
                miscompares++;
                $display("FAIL level scen%0d tick%0d got a=%b n=%b required %b",
                         s, sel[i].tick, lvl_a, lvl_n, sel[i].lvl);
            end
            btn_tbl = sel[i].btn;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_pulses scen%0d got %0d unmatched, required 0 (next edge=%0d)",
                     s, exp_q.size(), exp_q[0].edge_no);
            exp_q.delete();
        end
    endtask

    initial begin
        //    scen tick btn    lvl    press  rel    long
        // 0: held through reset; long, repeats, release beats a repeat on t23
        add(0,  0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0,  3, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
        add(0, 11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11);
        add(0, 15, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
        add(0, 19, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
        add(0, 20, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 23, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
        add(0, 26, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // 1: two-tick glitch on ch0 is rejected
        add(1,  0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1,  1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1,  3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1,  8, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // 2: clean ch0 press with long and repeats, then release
        add(2,  0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add(2,  1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add(2,  4, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
        add(2, 12, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        add(2, 16, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
        add(2, 20, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
        add(2, 22, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        add(2, 24, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
        add(2, 25, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        add(2, 28, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // 3: ch1 release accepted on the tick long would fire
        add(3,  0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add(3,  1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        add(3,  4, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00);
        add(3,  9, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
        add(3, 12, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        add(3, 16, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // 4: ch0 normal while ch1 bounces (bounce enabled around this run)
        add(4,  0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add(4,  1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add(4,  4, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
        add(4,  8, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        add(4, 11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        add(4, 14, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // 5: drive ch0 into LONG and stop there
        add(5,  0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add(5,  3, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
        add(5, 11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        add(5, 13, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        // 6: reset hits while in LONG, button still held: re-qualifies from scratch
        add(6,  0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add(6,  3, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
        add(6,  4, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        add(6,  7, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        add(6,  9, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        @(posedge clk);
        #1;
        for (int s = 0; s < 7; s++) begin
            bounce_en = (s == 4);
            run_scen(s);
            $display("scenario %0d done: %0d vectors, %0d miscompares so far", s, vectors, miscompares);
        end
        bounce_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
